// File: rtl/mips_mem_arbiter.sv
// Arbiter that shares one single-ported synchronous memory between the
// instruction-fetch port and the load/store port of mips_top.
module mips_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_DGRANT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LP_LAT  = 4'(MEM_LAT);
    localparam logic [3:0] LP_DMAX = 4'(MAX_DGRANT);

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_wcnt;
    logic [3:0]        r_dcount;
    logic              r_owner_d;
    logic              r_we;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_valid;
    logic              r_d_valid;
    logic              w_grant_d;
    logic              w_grant_i;

    // Data first; a waiting fetch is forced ahead once the data port has
    // won MAX_DGRANT contended grants in a row.
    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (r_state == S_IDLE) begin
            if (d_req && i_req) begin
                if (r_dcount == LP_DMAX) w_grant_i = 1'b1;
                else                     w_grant_d = 1'b1;
            end else if (d_req) begin
                w_grant_d = 1'b1;
            end else if (i_req) begin
                w_grant_i = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_d || w_grant_i) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = r_we ? S_RESP : S_WAIT;
            S_WAIT:  if (r_wcnt == 4'd1) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wcnt      <= '0;
            r_dcount    <= '0;
            r_owner_d   <= 1'b0;
            r_we        <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_valid   <= 1'b0;
            r_d_valid   <= 1'b0;
        end else begin
            r_mem_en  <= 1'b0;
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_owner_d   <= 1'b1;
                        r_we        <= d_we;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        if (!i_req)                r_dcount <= '0;
                        else if (r_dcount < LP_DMAX) r_dcount <= r_dcount + 4'd1;
                    end else if (w_grant_i) begin
                        r_owner_d  <= 1'b0;
                        r_we       <= 1'b0;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= i_addr;
                        r_dcount   <= '0;
                    end
                end
                S_ISSUE: begin
                    r_mem_we <= 1'b0;
                    r_wcnt   <= LP_LAT;
                    if (r_we) r_d_valid <= 1'b1;
                end
                S_WAIT: begin
                    r_wcnt <= r_wcnt - 4'd1;
                    if (r_wcnt == 4'd1) begin
                        if (r_owner_d) begin
                            r_d_rdata <= mem_rdata;
                            r_d_valid <= 1'b1;
                        end else begin
                            r_i_rdata <= mem_rdata;
                            r_i_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_valid   = r_i_valid;
    assign d_valid   = r_d_valid;
    assign stall     = (i_req & ~r_i_valid) | (d_req & ~r_d_valid);
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: per-cycle vector table plus
// contention, reset-abort and MEM_LAT=1 sequences.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 0, d_req = 0, d_we = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_valid, d_valid, mem_en, mem_we, stall, busy;

    logic        i_req1 = 0;
    logic [31:0] i_addr1 = 0;
    logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        i_valid1, d_valid1, mem_en1, mem_we1, stall1, busy1;
    logic        d_req1 = 0, d_we1 = 0;
    logic [31:0] d_addr1 = 0, d_wdata1 = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.MEM_LAT(2), .MAX_DGRANT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall(stall), .busy(busy)
    );

    mips_mem_arbiter #(.MEM_LAT(1), .MAX_DGRANT(4)) dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_valid(i_valid1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_valid(d_valid1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .stall(stall1), .busy(busy1)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h40) return 32'h20080005;
        return a ^ 32'h5A5A0000;
    endfunction

    // Memory models: data appears only in the exact latency cycle, a marker otherwise.
    logic [31:0] m_p1, m_p2, n_p1;
    always @(posedge clk) begin
        m_p1 <= mem_en ? memf(mem_addr) : 32'hBAD00000;
        m_p2 <= m_p1;
        n_p1 <= mem_en1 ? memf(mem_addr1) : 32'hBAD00001;
    end
    assign mem_rdata  = m_p2;
    assign mem_rdata1 = n_p1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_iv;
        logic [31:0] e_ird;
        logic        e_dv;
        logic [31:0] e_drd;
        logic        e_stall;
        logic        e_busy;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];
    logic [31:0] got [10];
    logic [31:0] exp_seq [10];
    int ng, nv, lat;

    initial begin
        logic [31:0] ir;
        ir = 32'h20080005;
        //            ir ia      dr dw da      dwd           en we addr    wdata         iv ird    dv drd           st bz
        vt[0]  = '{0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        0, 32'h0, 0, 32'h0,       0, 0};
        vt[1]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        0, 32'h0, 0, 32'h0,       1, 0};
        vt[2]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        1, 0, 32'h40,  32'h0,        0, 32'h0, 0, 32'h0,       1, 1};
        vt[3]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 32'h40,  32'h0,        0, 32'h0, 0, 32'h0,       1, 1};
        vt[4]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 32'h40,  32'h0,        0, 32'h0, 0, 32'h0,       1, 1};
        vt[5]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 32'h40,  32'h0,        1, ir,    0, 32'h0,       0, 1};
        vt[6]  = '{0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h40,  32'h0,        0, ir,    0, 32'h0,       0, 0};
        vt[7]  = '{0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 32'h40,  32'h0,        0, ir,    0, 32'h0,       1, 0};
        vt[8]  = '{0, 32'h0,  1, 0, 32'h300, 32'h12345678, 1, 1, 32'h100, 32'hDEADBEEF, 0, ir,    0, 32'h0,       1, 1};
        vt[9]  = '{0, 32'h0,  1, 0, 32'h300, 32'h12345678, 0, 0, 32'h100, 32'hDEADBEEF, 0, ir,    1, 32'h0,       0, 1};
        vt[10] = '{0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h100, 32'hDEADBEEF, 0, ir,    0, 32'h0,       0, 0};
        vt[11] = '{0, 32'h0,  1, 0, 32'h100, 32'h0,        0, 0, 32'h100, 32'hDEADBEEF, 0, ir,    0, 32'h0,       1, 0};
        vt[12] = '{0, 32'h0,  0, 0, 32'h300, 32'h0,        1, 0, 32'h100, 32'h0,        0, ir,    0, 32'h0,       0, 1};
        vt[13] = '{0, 32'h0,  0, 0, 32'h300, 32'h0,        0, 0, 32'h100, 32'h0,        0, ir,    0, 32'h0,       0, 1};
        vt[14] = '{0, 32'h0,  0, 0, 32'h300, 32'h0,        0, 0, 32'h100, 32'h0,        0, ir,    0, 32'h0,       0, 1};
        vt[15] = '{0, 32'h0,  0, 0, 32'h300, 32'h0,        0, 0, 32'h100, 32'h0,        0, ir,    1, 32'h5A5A0100, 0, 1};
        vt[16] = '{0, 32'h0,  0, 0, 32'h300, 32'h0,        0, 0, 32'h100, 32'h0,        0, ir,    0, 32'h5A5A0100, 0, 0};
        vt[17] = '{0, 32'h0,  0, 0, 32'h300, 32'h0,        0, 0, 32'h100, 32'h0,        0, ir,    0, 32'h5A5A0100, 0, 0};

        for (int k = 0; k < 10; k++) exp_seq[k] = (k % 5 == 4) ? 32'h0 : 32'h200;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Instruction read, write with post-grant input changes, read latching.
        for (int r = 0; r < NV; r++) begin
            @(negedge clk);
            i_req = vt[r].ir; i_addr = vt[r].ia;
            d_req = vt[r].dr; d_we = vt[r].dw; d_addr = vt[r].da; d_wdata = vt[r].dwd;
            #1;
            $display("vec %0d: en=%b we=%b addr=%h iv=%b dv=%b stall=%b busy=%b",
                     r, mem_en, mem_we, mem_addr, i_valid, d_valid, stall, busy);
            chk($sformatf("v%0d_mem_en", r),    32'(mem_en),    32'(vt[r].e_en));
            chk($sformatf("v%0d_mem_we", r),    32'(mem_we),    32'(vt[r].e_we));
            chk($sformatf("v%0d_mem_addr", r),  mem_addr,       vt[r].e_addr);
            chk($sformatf("v%0d_mem_wdata", r), mem_wdata,      vt[r].e_wdata);
            chk($sformatf("v%0d_i_valid", r),   32'(i_valid),   32'(vt[r].e_iv));
            chk($sformatf("v%0d_i_rdata", r),   i_rdata,        vt[r].e_ird);
            chk($sformatf("v%0d_d_valid", r),   32'(d_valid),   32'(vt[r].e_dv));
            chk($sformatf("v%0d_d_rdata", r),   d_rdata,        vt[r].e_drd);
            chk($sformatf("v%0d_stall", r),     32'(stall),     32'(vt[r].e_stall));
            chk($sformatf("v%0d_busy", r),      32'(busy),      32'(vt[r].e_busy));
        end

        // Contention: both ports held high; expect D,D,D,D,I repeating.
        i_req = 1; i_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h200;
        ng = 0; nv = 0;
        for (int c = 0; c < 300 && nv < 10; c++) begin
            @(negedge clk); #1;
            if (mem_en) begin
                if (ng < 10) got[ng] = mem_addr;
                ng++;
            end
            if (d_valid) begin
                nv++;
                chk("cont_d_rdata", d_rdata, 32'h5A5A0200);
            end
            if (i_valid) begin
                nv++;
                chk("cont_i_rdata", i_rdata, 32'h5A5A0000);
            end
        end
        i_req = 0; d_req = 0;
        chk("cont_grants", ng, 10);
        chk("cont_valids", nv, 10);
        for (int k = 0; k < 10 && k < ng; k++) begin
            $display("grant %0d: addr=%h", k, got[k]);
            chk($sformatf("cont_order%0d", k), got[k], exp_seq[k]);
        end

        // Reset asserted in WAIT of a data read takes effect without a clock edge.
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h200;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        $display("reset mid-access: busy=%b addr=%h ird=%h drd=%h", busy, mem_addr, i_rdata, d_rdata);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_d_valid", 32'(d_valid), 32'h0);
        d_req = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            chk($sformatf("abort_no_dvalid%0d", c), 32'(d_valid), 32'h0);
        end

        // Fresh instruction read after the abort: valid four cycles after sampling.
        @(negedge clk);
        i_req = 1; i_addr = 32'h40;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk); #1;
            if (i_valid) begin lat = c; break; end
        end
        i_req = 0;
        $display("post-reset fetch: latency=%0d data=%h", lat, i_rdata);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_i_rdata", i_rdata, 32'h20080005);

        // MEM_LAT=1 instance: valid three cycles after sampling.
        @(negedge clk);
        i_req1 = 1; i_addr1 = 32'h80;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk); #1;
            if (i_valid1) begin lat = c; break; end
        end
        i_req1 = 0;
        $display("lat1 fetch: latency=%0d data=%h", lat, i_rdata1);
        chk("lat1_latency", lat, 3);
        chk("lat1_i_rdata", i_rdata1, 32'h5A5A0080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares one single-ported synchronous memory between two requesters in mips_top: the instruction-fetch port (read-only) and the load/store data port (read/write).
- Serialises accesses through a small FSM and returns read data or write completion to the requester that issued it.
- Drives a global stall so the datapath freezes while a request is outstanding.
- Arbitration is data-first, with an anti-starvation cap for instruction fetch.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MEM_LAT, 2, cycles from the memory issue cycle to valid mem_rdata (legal range 1..15).
- MAX_DGRANT, 4, consecutive contended data grants allowed before a pending instruction request is forced ahead (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction read request; held high until i_valid.
- i_addr  in  ADDR_W  instruction address.
- i_rdata  out  DATA_W  instruction read data; holds the last value read.
- i_valid  out  1  one-cycle completion pulse for the instruction port.
- d_req  in  1  data request; held high until d_valid.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  data read result; holds the last value read.
- d_valid  out  1  one-cycle completion pulse for the data port (read or write).
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.
- stall  out  1  pipeline freeze.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset, asynchronous and effective immediately:
  - State goes to IDLE.
  - mem_en, mem_we, i_valid, d_valid = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - Grant counter dcount = 0.
  - Any in-flight access is abandoned; late mem_rdata is ignored and no valid pulse follows.
- All outputs except stall and busy are registered.
- stall is combinational: (i_req & ~i_valid) | (d_req & ~d_valid).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled only in this state.
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner, latch its address, write enable and write data plus the owner id, and go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_en = 1; mem_we, mem_addr and mem_wdata come from the latched values.
  - Write: go to RESP.
  - Read: load the wait counter with MEM_LAT and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, mem_rdata is captured into the owner's rdata register and the FSM goes to RESP.
- RESP (one cycle):
  - The owner's valid pulse is asserted; its rdata is already updated.
  - Next state is IDLE, which gives the requester one cycle to present its next request.
- Latency, with a request sampled in IDLE at cycle T:
  - mem_en at T+1.
  - Read valid at T+2+MEM_LAT.
  - Write valid at T+2.
- Arbitration in IDLE:
  - Only d_req pending: data wins.
  - Only i_req pending: instruction wins.
  - Both pending: data wins unless dcount == MAX_DGRANT, in which case instruction wins.
- dcount update:
  - Increments, saturating at MAX_DGRANT, on a data grant made while i_req was high.
  - Clears on any instruction grant.
  - Clears on a data grant made while i_req was low.
- Input changes after the grant (address, wdata, we, or dropping req) do not affect the current access; the valid pulse is still issued.
- The non-owner's rdata and valid are untouched during an access.
- busy = 1 in ISSUE, WAIT and RESP.

Test Plan:
1. Instruction read with MEM_LAT=2: after reset release, i_req=1, i_addr=0x00000040 sampled at T; memory returns 0x20080005 -> mem_en=1, mem_we=0, mem_addr=0x40 at T+1; i_valid=1, i_rdata=0x20080005 at T+4; stall=1 over T..T+3 and 0 at T+4.
2. Data write: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF at T -> at T+1 mem_en=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; d_valid at T+2; i_rdata and d_rdata unchanged.
3. Contention: i_req and d_req held high continuously (data reads at 0x200, instruction reads at 0x0) -> grant order seen on mem_addr is D,D,D,D,I,D,D,D,D,I; no grant is lost.
4. Reset mid-access: assert reset during WAIT of a data read -> mem_en, valids and rdata go to 0 without waiting for a clock edge; after release, no d_valid for the aborted read, and a new i_req is served with T+4 latency.
5. Latching: change d_addr 0x100 -> 0x300 and drop d_req one cycle after the grant -> mem_addr=0x100; d_valid still pulses; no second access is issued.
6. MEM_LAT=1 build: instruction read sampled at T -> i_valid at T+3 with mem_rdata captured from cycle T+2.
